// File: rtl/pixel_stream_out.sv
// rtl/pixel_stream_out.sv - captures a Q8.8 frame and streams it as 8-bit grey levels in raster order.
// Optional saturation of out-of-range pixels: define PIXEL_STREAM_OUT_CLAMP_EN (default wraps).
module pixel_stream_out #(
    parameter int PIXEL_COUNT = 784,
    parameter int ROW_WIDTH   = 28,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] vector_in,
    output logic                              busy,
    output logic                              done,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [OUT_WIDTH-1:0]              m_data,
    output logic                              m_row_end,
    output logic                              m_last
);
    localparam int IDX_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam int COL_W = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int SHIFT = FRAC_BITS + 1 - OUT_WIDTH;
    localparam int UW    = DATA_WIDTH + 2;

    localparam logic signed [UW-1:0] BIAS     = UW'(1) << FRAC_BITS;
    localparam logic signed [UW-1:0] OUT_MAX  = UW'((1 << OUT_WIDTH) - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(ROW_WIDTH - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] frame_q [PIXEL_COUNT];
    logic [IDX_W-1:0]      pix_q;
    logic [COL_W-1:0]      col_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic [OUT_WIDTH-1:0]  data_q;
    logic                  row_end_q;
    logic                  last_q;

    logic [IDX_W-1:0]      pix_d;
    logic [COL_W-1:0]      col_d;

    // Bias maps -1.0..+1.0 onto 0..2.0, then the shift keeps the top OUT_WIDTH integer+fraction bits.
    function automatic logic [OUT_WIDTH-1:0] convert(input logic [DATA_WIDTH-1:0] x);
        logic signed [UW-1:0] u;
        logic signed [UW-1:0] s;
        u = $signed({{2{x[DATA_WIDTH-1]}}, x}) + BIAS;
        s = u >>> SHIFT;
`ifdef PIXEL_STREAM_OUT_CLAMP_EN
        if (s < 0) begin
            return '0;
        end else if (s > OUT_MAX) begin
            return '1;
        end else begin
            return s[OUT_WIDTH-1:0];
        end
`else
        return s[OUT_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        pix_d = pix_q + 1'b1;
        col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            col_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            row_end_q <= 1'b0;
            last_q    <= 1'b0;
            for (int i = 0; i < PIXEL_COUNT; i++) begin
                frame_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < PIXEL_COUNT; i++) begin
                            frame_q[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        state_q   <= STREAM;
                        pix_q     <= '0;
                        col_q     <= '0;
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        data_q    <= convert(vector_in[DATA_WIDTH-1:0]);
                        row_end_q <= (ROW_WIDTH == 1);
                        last_q    <= (PIXEL_COUNT == 1);
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (last_q) begin
                            state_q   <= IDLE;
                            pix_q     <= '0;
                            col_q     <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            valid_q   <= 1'b0;
                            data_q    <= '0;
                            row_end_q <= 1'b0;
                            last_q    <= 1'b0;
                        end else begin
                            // Next pixel is pre-converted so m_data never depends on m_ready combinationally.
                            pix_q     <= pix_d;
                            col_q     <= col_d;
                            data_q    <= convert(frame_q[pix_d]);
                            row_end_q <= (col_d == LAST_COL);
                            last_q    <= (pix_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign m_valid   = valid_q;
    assign m_data    = data_q;
    assign m_row_end = row_end_q;
    assign m_last    = last_q;
endmodule

// File: tb/tb_pixel_stream_out.sv
// tb/tb_pixel_stream_out.sv - randomized self-checking bench for pixel_stream_out.
module tb_pixel_stream_out;
    localparam int PC   = 784;
    localparam int ROW  = 28;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int OW   = 8;
    localparam int SH   = FRAC + 1 - OW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [DW*PC-1:0] vin;
    logic             busy, done, m_valid, m_ready, m_row_end, m_last;
    logic [OW-1:0]    m_data;

    int pass_cnt = 0;
    int total    = 0;
    int pix [PC];

    always #5 clk = ~clk;

    pixel_stream_out #(
        .PIXEL_COUNT(PC), .ROW_WIDTH(ROW), .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vector_in(vin),
        .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_row_end(m_row_end), .m_last(m_last)
    );

    // Reference: real-valued pixel x/256 mapped to grey = floor((x + 256) / 2), then saturated or wrapped.
    function automatic int conv(int x);
        int s;
        s = (x + (1 << FRAC)) >>> SH;
`ifdef PIXEL_STREAM_OUT_CLAMP_EN
        if (s < 0) return 0;
        if (s > (1 << OW) - 1) return (1 << OW) - 1;
        return s;
`else
        return s & ((1 << OW) - 1);
`endif
    endfunction

    task automatic set_pix(input int i, input logic [DW-1:0] v);
        pix[i] = int'($signed(v));
        vin[i*DW +: DW] = v;
    endtask

    task automatic random_frame();
        for (int i = 0; i < PC; i++) set_pix(i, DW'($urandom));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called one cycle after start was sampled; checks every cycle until done (or abort).
    task automatic stream(input bit rnd, input int inject_idx, input int abort_idx,
                          input bit restart, input string tag);
        int idx = 0;
        int cyc = 1;
        bit fin = 1'b0;
        bit injected = 1'b0;
        logic [DW*PC-1:0] saved;
        saved = vin;
        while (!fin && cyc < 4 * PC) begin
            if (start) begin
                start = 1'b0;
                vin = saved;
            end
            if (idx == abort_idx) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                total++;
                if ({busy, done, m_valid, m_data, m_row_end, m_last} !== '0)
                    $display("FAIL %s abort_outputs got %h exp 0", tag,
                             {busy, done, m_valid, m_data, m_row_end, m_last});
                else pass_cnt++;
                fin = 1'b1;
            end else begin
                total++;
                if ({m_valid, busy, done} !== 3'b110)
                    $display("FAIL %s ctl idx=%0d got v/b/d=%b exp 110", tag, idx, {m_valid, busy, done});
                else pass_cnt++;
                total++;
                if (m_data !== OW'(conv(pix[idx])))
                    $display("FAIL %s data idx=%0d got %0d exp %0d", tag, idx, m_data, conv(pix[idx]));
                else pass_cnt++;
                total++;
                if ({m_row_end, m_last} !== {1'(idx % ROW == ROW - 1), 1'(idx == PC - 1)})
                    $display("FAIL %s markers idx=%0d got %b%b exp %b%b", tag, idx, m_row_end, m_last,
                             idx % ROW == ROW - 1, idx == PC - 1);
                else pass_cnt++;
                if (idx == inject_idx && !injected) begin
                    vin = ~saved;
                    start = 1'b1;
                    injected = 1'b1;
                end
                m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_ready) idx++;
                @(posedge clk); #1;
                cyc++;
                if (idx == PC) begin
                    if (start) begin
                        start = 1'b0;
                        vin = saved;
                    end
                    total++;
                    if ({done, busy, m_valid} !== 3'b100)
                        $display("FAIL %s done_cycle got d/b/v=%b exp 100", tag, {done, busy, m_valid});
                    else pass_cnt++;
                    if (!rnd) begin
                        total++;
                        if (cyc != PC + 1) $display("FAIL %s latency got %0d exp %0d", tag, cyc, PC + 1);
                        else pass_cnt++;
                    end
                    if (restart) begin
                        do_start();
                    end else begin
                        @(posedge clk); #1;
                        total++;
                        if ({done, busy, m_valid} !== 3'b000)
                            $display("FAIL %s after_done got d/b/v=%b exp 000", tag, {done, busy, m_valid});
                        else pass_cnt++;
                    end
                    fin = 1'b1;
                end
            end
        end
        if (!fin) begin
            total++;
            $display("FAIL %s timeout got idx=%0d exp %0d", tag, idx, PC);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; m_ready = 1'b1; vin = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done, m_valid, m_data, m_row_end, m_last} !== '0)
                $display("FAIL reset_idle cycle=%0d got %h exp 0", c,
                         {busy, done, m_valid, m_data, m_row_end, m_last});
            else pass_cnt++;
        end
    endtask

    task automatic test_pattern();
        logic [DW-1:0] pat [4];
        pat[0] = 16'h0000; pat[1] = 16'hFF00; pat[2] = 16'h0080; pat[3] = 16'h00FF;
        for (int i = 0; i < PC; i++) set_pix(i, pat[i % 4]);
        do_start();
        stream(1'b0, -1, -1, 1'b0, "pattern");
    endtask

    task automatic test_backpressure();
        do_start();
        stream(1'b1, -1, -1, 1'b0, "backpressure");
        m_ready = 1'b1;
    endtask

    task automatic test_saturation();
        random_frame();
        set_pix(0, 16'h0100);
        set_pix(1, 16'hFE00);
        set_pix(2, 16'h7FFF);
        do_start();
        stream(1'b0, -1, -1, 1'b0, "saturation");
    endtask

    task automatic test_start_ignored();
        random_frame();
        do_start();
        stream(1'b0, 100, -1, 1'b1, "mid_start");
        stream(1'b1, -1, -1, 1'b0, "start_on_done");
        m_ready = 1'b1;
    endtask

    task automatic test_abort();
        random_frame();
        do_start();
        stream(1'b0, -1, 300, 1'b0, "abort");
        random_frame();
        do_start();
        stream(1'b0, -1, -1, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_backpressure();
        test_saturation();
        test_start_ignored();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
